// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the RAM.
// The master side is the requesters plus RAM; the slave side is the arbiter.
interface vram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output vid_req, vid_addr,
        input  vid_ack, vid_rvalid, vid_rdata,
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  ram_addr, ram_we, ram_be, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  vid_req, vid_addr,
        output vid_ack, vid_rvalid, vid_rdata,
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output ram_addr, ram_we, ram_be, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: pipelined video reads with priority, CPU handshake
// accesses, and a starvation limiter that forces a CPU slot.
module vram_arbiter #(
    parameter int AW           = 14,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA,
        ACK
    } state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t        state;
    logic [3:0]    starve;
    logic          rd_pipe;
    logic          rvalid_q;
    logic          cpu_rd;
    logic          ack_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [1:0]    be_q;
    logic [DW-1:0] wdata_q;

    logic cpu_pend;
    logic cpu_sel;
    logic cpu_win;
    logic vid_win;

    assign cpu_pend = bus.cpu_req & (state == IDLE);
    assign cpu_sel  = cpu_pend & (~bus.vid_req | (starve == LIM));

    always_comb begin
        cpu_win = 1'b0;
        vid_win = 1'b0;
        unique case (1'b1)
            cpu_sel:                 cpu_win = 1'b1;
            bus.vid_req & ~cpu_sel:  vid_win = 1'b1;
            default: ;
        endcase
    end

    assign bus.vid_ack    = vid_win;
    assign bus.vid_rvalid = rvalid_q;
    assign bus.vid_rdata  = rvalid_q ? bus.ram_rdata : '0;
    assign bus.cpu_ack    = ack_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_we     = we_q;
    assign bus.ram_be     = be_q;
    assign bus.ram_wdata  = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            starve   <= '0;
            rd_pipe  <= 1'b0;
            rvalid_q <= 1'b0;
            cpu_rd   <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            we_q     <= 1'b0;
            rd_pipe  <= vid_win;
            rvalid_q <= rd_pipe;

            // Video issues only move the address; be/wdata keep the last CPU values
            if (cpu_win) begin
                addr_q  <= bus.cpu_addr;
                we_q    <= bus.cpu_we;
                be_q    <= bus.cpu_be;
                wdata_q <= bus.cpu_wdata;
                cpu_rd  <= ~bus.cpu_we;
            end else if (vid_win) begin
                addr_q <= bus.vid_addr;
            end

            if (vid_win && cpu_pend) begin
                starve <= (starve == LIM) ? starve : starve + 4'd1;
            end else begin
                starve <= '0;
            end

            unique case (state)
                IDLE: begin
                    if (cpu_win) state <= ISSUE;
                end
                ISSUE: state <= DATA;
                DATA: begin
                    if (cpu_rd) rdata_q <= bus.ram_rdata;
                    ack_q <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    if (!bus.cpu_req) begin
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
// Table-driven CPU accesses plus hand-written multi-cycle sequences.
module tb_vram_arbiter;
    logic clk = 1'b0;
    logic reset;

    vram_arbiter_if #(.AW(14), .DW(16)) vif ();

    vram_arbiter #(
        .AW(14),
        .DW(16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:16383];

    // RAM preloads data=addr while reset is held
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'(i);
        end else if (vif.ram_we) begin
            if (vif.ram_be[0]) mem[vif.ram_addr][7:0]  <= vif.ram_wdata[7:0];
            if (vif.ram_be[1]) mem[vif.ram_addr][15:8] <= vif.ram_wdata[15:8];
        end
        vif.ram_rdata <= mem[vif.ram_addr];
    end

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [11];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] outs();
        return {4'b0, vif.vid_ack, vif.vid_rvalid, vif.vid_rdata,
                vif.cpu_ack, vif.cpu_rdata, vif.ram_addr, vif.ram_we,
                vif.ram_be, vif.ram_wdata};
    endfunction

    task automatic cpu_access(input vec_t v);
        tick();
        vif.cpu_req   = 1'b1;
        vif.cpu_we    = v.we;
        vif.cpu_be    = v.be;
        vif.cpu_addr  = v.addr;
        vif.cpu_wdata = v.wdata;
        #1;
        chk("cpu_grant_ack", 72'(vif.cpu_ack), 72'(0));
        tick();
        chk("cpu_ram_we", 72'(vif.ram_we), 72'(v.we));
        chk("cpu_ram_addr", 72'(vif.ram_addr), 72'(v.addr));
        chk("cpu_ram_be", 72'(vif.ram_be), 72'(v.be));
        if (v.we) chk("cpu_ram_wdata", 72'(vif.ram_wdata), 72'(v.wdata));
        chk("cpu_issue_ack", 72'(vif.cpu_ack), 72'(0));
        vif.cpu_addr  = ~v.addr;
        vif.cpu_we    = ~v.we;
        vif.cpu_wdata = 16'h0F0F;
        tick();
        chk("cpu_data_we", 72'(vif.ram_we), 72'(0));
        chk("cpu_data_ack", 72'(vif.cpu_ack), 72'(0));
        chk("cpu_data_addr", 72'(vif.ram_addr), 72'(v.addr));
        tick();
        chk("cpu_ack", 72'(vif.cpu_ack), 72'(1));
        chk("cpu_rdata", 72'(vif.cpu_rdata), 72'(v.exp));
        vif.cpu_req = 1'b0;
        tick();
        chk("cpu_ack_drop", 72'(vif.cpu_ack), 72'(0));
        chk("cpu_idle_we", 72'(vif.ram_we), 72'(0));
    endtask

    initial begin
        logic [13:0] va;
        logic [15:0] nexp;
        int          nack;
        int          nval;

        vt[0]  = '{1'b1, 2'b10, 14'h0200, 16'hBEEF, 16'h0000};
        vt[1]  = '{1'b0, 2'b00, 14'h0200, 16'h0000, 16'hBE00};
        vt[2]  = '{1'b1, 2'b11, 14'h0300, 16'h1234, 16'hBE00};
        vt[3]  = '{1'b0, 2'b00, 14'h0300, 16'h0000, 16'h1234};
        vt[4]  = '{1'b1, 2'b01, 14'h0301, 16'hAAAA, 16'h1234};
        vt[5]  = '{1'b0, 2'b00, 14'h0301, 16'h0000, 16'h03AA};
        vt[6]  = '{1'b1, 2'b00, 14'h0302, 16'hFFFF, 16'h03AA};
        vt[7]  = '{1'b0, 2'b00, 14'h0302, 16'h0000, 16'h0302};
        vt[8]  = '{1'b0, 2'b00, 14'h3FFF, 16'h0000, 16'h3FFF};
        vt[9]  = '{1'b1, 2'b11, 14'h0000, 16'h5555, 16'h3FFF};
        vt[10] = '{1'b0, 2'b00, 14'h0000, 16'h0000, 16'h5555};

        reset         = 1'b1;
        vif.vid_req   = 1'b0;
        vif.vid_addr  = '0;
        vif.cpu_req   = 1'b0;
        vif.cpu_we    = 1'b0;
        vif.cpu_be    = '0;
        vif.cpu_addr  = '0;
        vif.cpu_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_outputs", outs(), 72'(0));
        end

        // Video burst of 8
        va = 14'h100;
        for (int i = 0; i < 12; i++) begin
            tick();
            vif.vid_req  = (i < 8);
            vif.vid_addr = va;
            #1;
            if (i < 8) chk("burst_vid_ack", 72'(vif.vid_ack), 72'(1));
            chk("burst_rvalid", 72'(vif.vid_rvalid), 72'(i >= 2 && i < 10));
            if (i >= 2 && i < 10)
                chk("burst_rdata", 72'(vif.vid_rdata), 72'(16'h100 + 16'(i - 2)));
            chk("burst_ram_we", 72'(vif.ram_we), 72'(0));
            if (vif.vid_ack) va++;
        end

        for (int k = 0; k < 11; k++) cpu_access(vt[k]);

        // Starvation limiter under continuous video
        va   = 14'h100;
        nexp = 16'h100;
        nack = 0;
        nval = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (vif.vid_rvalid) begin
                chk("starve_rdata", 72'(vif.vid_rdata), 72'(nexp));
                nexp++;
                nval++;
            end
            if (i == 5) begin
                chk("starve_cpu_addr", 72'(vif.ram_addr), 72'(14'h0300));
                chk("starve_cpu_we", 72'(vif.ram_we), 72'(0));
            end
            chk("starve_cpu_ack", 72'(vif.cpu_ack), 72'(i == 7));
            if (i == 0) begin
                vif.cpu_req  = 1'b1;
                vif.cpu_we   = 1'b0;
                vif.cpu_be   = 2'b00;
                vif.cpu_addr = 14'h0300;
            end
            if (vif.cpu_ack) vif.cpu_req = 1'b0;
            vif.vid_req  = (i < 14);
            vif.vid_addr = va;
            #1;
            if (i < 14) chk("starve_vid_ack", 72'(vif.vid_ack), 72'(i != 4));
            if (vif.vid_ack) begin
                va++;
                nack++;
            end
        end
        chk("starve_word_count", 72'(nval), 72'(nack));
        chk("starve_ack_count", 72'(nack), 72'(13));
        chk("starve_cpu_rdata", 72'(vif.cpu_rdata), 72'(16'h1234));

        // CPU holds request long after ack
        tick();
        vif.cpu_req  = 1'b1;
        vif.cpu_we   = 1'b0;
        vif.cpu_addr = 14'h0301;
        #1;
        chk("hold_vid_ack", 72'(vif.vid_ack), 72'(0));
        tick();
        chk("hold_ram_addr", 72'(vif.ram_addr), 72'(14'h0301));
        vif.cpu_addr = 14'h0123;
        tick();
        tick();
        chk("hold_ack", 72'(vif.cpu_ack), 72'(1));
        chk("hold_rdata", 72'(vif.cpu_rdata), 72'(16'h03AA));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_ack_held", 72'(vif.cpu_ack), 72'(1));
            chk("hold_no_reissue", 72'(vif.ram_addr), 72'(14'h0301));
            chk("hold_no_we", 72'(vif.ram_we), 72'(0));
        end
        vif.cpu_req = 1'b0;
        tick();
        chk("hold_ack_clear", 72'(vif.cpu_ack), 72'(0));
        tick();
        chk("hold_idle_addr", 72'(vif.ram_addr), 72'(14'h0301));

        // Reset with a video read and a CPU read in flight
        tick();
        vif.cpu_req  = 1'b1;
        vif.cpu_we   = 1'b0;
        vif.cpu_addr = 14'h0300;
        tick();
        vif.vid_req  = 1'b1;
        vif.vid_addr = 14'h0104;
        #1;
        chk("rst_vid_ack", 72'(vif.vid_ack), 72'(1));
        tick();
        vif.vid_req = 1'b0;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        vif.cpu_req = 1'b0;
        chk("rst_outputs", outs(), 72'(0));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_quiet", outs(), 72'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
